mod_residue_encoder: RTL and testbench

//  Sequential binary-to-residue encoder. It reduces a W-bit unsigned binary word to its

---
 rtl/mod_residue_encoder_pkg.sv | 24 ++
 rtl/mod_residue_encoder_if.sv | 29 ++
 rtl/mod_residue_encoder_eac_adder.sv | 21 ++
 rtl/mod_residue_encoder.sv | 84 ++++++++
 tb/tb_mod_residue_encoder.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mod_residue_encoder_pkg.sv
// =============================================================================
// mod_residue_encoder_pkg : shared constants and FSM encoding for residue encoder
// Rev 1.0
// =============================================================================
`default_nettype none

package mod_residue_encoder_pkg;

  localparam int RES_N = 4;
  localparam int BIN_W = 16;
  localparam int K     = BIN_W / RES_N;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [RES_N-1:0] ALL_ONES = {RES_N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FOLD = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mod_residue_encoder_if.sv
// =============================================================================
// mod_residue_encoder_if : input word / output residue handshake bundle
// Rev 1.0
// =============================================================================
`default_nettype none

interface mod_residue_encoder_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_res;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_res
  );
endinterface

`default_nettype wire

// File: rtl/mod_residue_encoder_eac_adder.sv
// =============================================================================
// eac_adder : N-bit end-around-carry adder (ones'-complement style, mod 2^N-1)
// Rev 1.0
// =============================================================================
`default_nettype none

module eac_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);
  logic [N:0] w_full;

  // Wrapping the carry back in cannot overflow: max low part is 2^N-2 when carry is set.
  assign w_full = {1'b0, a} + {1'b0, b};
  assign sum    = w_full[N-1:0] + {{(N-1){1'b0}}, w_full[N]};
endmodule

`default_nettype wire

// File: rtl/mod_residue_encoder.sv
// =============================================================================
// mod_residue_encoder : sequential binary -> canonical residue mod 2^N-1 encoder
// Rev 1.0
// =============================================================================
`default_nettype none

module mod_residue_encoder
  import mod_residue_encoder_pkg::*;
#(
  parameter int N = RES_N,
  parameter int W = BIN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mod_residue_encoder_if.slave bus
);
  localparam int KC = W / N;
  localparam int CW = (KC > 1) ? $clog2(KC) : 1;
  localparam logic [CW-1:0] c_last = CW'(KC - 1);
  localparam logic [N-1:0]  c_ones = {N{1'b1}};

  state_t        r_state;
  logic [W-1:0]  r_shreg;
  logic [N-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_res;
  logic          r_out_valid;
  logic [N-1:0]  w_sum;

  eac_adder #(.N(N)) u_eac (
    .a   (r_acc),
    .b   (r_shreg[N-1:0]),
    .sum (w_sum)
  );

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_res   = r_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_shreg <= bus.in_data;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_FOLD;
          end
        end
        S_FOLD: begin
          r_acc   <= w_sum;
          r_shreg <= r_shreg >> N;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == c_last) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          // All-ones is the redundant encoding of zero; emit the canonical form.
          r_res       <= (r_acc == c_ones) ? '0 : r_acc;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mod_residue_encoder.sv
// =============================================================================
// tb_mod_residue_encoder : directed-vector and stall/reset bench for the encoder
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_mod_residue_encoder;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mod_residue_encoder_if #(.N(4), .W(16)) bus ();

  mod_residue_encoder #(.N(4), .W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  e;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, wait for its residue, optionally stall, then complete the handshake.
  task automatic run_word(input logic [15:0] d, input logic [3:0] exp,
                          input bit chk_lat, input bit rnd, input string nm);
    int lat;
    int stall;
    lat = 0;
    while (!bus.in_ready && lat < 50) begin tick(); lat++; end
    check({nm, " ready_wait"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    check({nm, " out_valid"}, 32'(bus.out_valid), 32'd1);
    if (chk_lat) check({nm, " latency"}, 32'(lat), 32'd5);
    check({nm, " out_res"}, 32'(bus.out_res), 32'(exp));
    stall = rnd ? int'($urandom_range(0, 3)) : 0;
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      repeat (stall) tick();
      check({nm, " stall_hold"}, {27'd0, bus.out_valid, bus.out_res}, {27'd0, 1'b1, exp});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({nm, " out_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] d;
    errors        = 0;
    checks        = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    vecs[0] = '{16'h1234, 4'hA};
    vecs[1] = '{16'hFFFF, 4'h0};
    vecs[2] = '{16'h000F, 4'h0};
    vecs[3] = '{16'h0010, 4'h1};
    vecs[4] = '{16'h0000, 4'h0};
    vecs[5] = '{16'h000E, 4'hE};
    vecs[6] = '{16'hABCD, 4'h1};
    vecs[7] = '{16'h8000, 4'h8};
    vecs[8] = '{16'h7FFF, 4'h7};
    vecs[9] = '{16'h1111, 4'h4};

    #12;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_res", 32'(bus.out_res), 32'd0);
    rst_n = 1'b1;
    tick();
    check("reset in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_word(vecs[i].d, vecs[i].e, 1'b1, 1'b0, $sformatf("vec%0d", i));
    end

    // Backpressure: second word presented throughout a 10-cycle stall.
    run_word(16'h0000, 4'h0, 1'b0, 1'b0, "pre_bp");
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    tick();
    bus.in_data  = 16'h0021;
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check("bp first valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp hold%0d", i),
            {26'd0, bus.in_ready, bus.out_valid, bus.out_res}, {26'd0, 1'b0, 1'b1, 4'hA});
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp back to idle", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
    tick();
    bus.in_valid = 1'b0;
    check("bp second accepted", 32'(bus.in_ready), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check("bp second latency", 32'(n), 32'd5);
    check("bp second res", 32'(bus.out_res), 32'h3);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Async reset while a result is pending in DONE.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("done pending", {27'd0, bus.out_valid, bus.out_res}, {27'd0, 1'b1, 4'hA});
    #2 rst_n = 1'b0;
    #1;
    check("rst done out_valid", 32'(bus.out_valid), 32'd0);
    check("rst done out_res", 32'(bus.out_res), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Async reset two cycles into FOLD: word must vanish.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst fold out_valid", 32'(bus.out_valid), 32'd0);
    check("rst fold out_res", 32'(bus.out_res), 32'd0);
    #3 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) n++;
    end
    check("no stale result", 32'(n), 32'd0);
    run_word(16'h0021, 4'h3, 1'b1, 1'b0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      run_word(d, 4'(d % 16'd15), 1'b0, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
